// File: rtl/par_chk_rx.sv
// Bit-serial parity checker: collects DATA_W data bits (LSB first) plus one parity bit,
// then presents the word and a parity-error flag on a valid/ready output. Macro: PAR_CHK_ERRCNT_EN.
module par_chk_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and the payload is held stable while valid is high.
    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                perr_q, perr_d;
    logic                bit_acc;
    logic                frame_done;

    assign in_ready  = (state_q == S_COLLECT);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign out_perr  = perr_q;
    assign bit_acc   = in_valid && (state_q == S_COLLECT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        shift_d    = shift_q;
        data_d     = data_q;
        perr_d     = perr_q;
        frame_done = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (bit_acc) begin
                    if (cnt_q == LAST_IDX) begin
                        data_d     = shift_q;
                        perr_d     = par_q ^ in_bit ^ PARITY_ODD;
                        cnt_d      = '0;
                        par_d      = 1'b0;
                        frame_done = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        // Overwrite one slot so stale bits from the previous frame never leak in
                        shift_d = (shift_q & ~(ONE << cnt_q)) | (DATA_W'(in_bit) << cnt_q);
                        par_d   = par_q ^ in_bit;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

`ifdef PAR_CHK_ERRCNT_EN
    logic [7:0] errc_q, errc_d;

    always_comb begin
        errc_d = errc_q;
        if (frame_done && perr_d && (errc_q != 8'hFF)) begin
            errc_d = errc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errc_q <= 8'h00;
        end else begin
            errc_q <= errc_d;
        end
    end

    assign err_cnt = errc_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign err_cnt           = 8'h00;
`endif

endmodule

// File: tb/tb_par_chk_rx.sv
// Bench for par_chk_rx: an even-parity and an odd-parity instance driven by directed
// and randomized frames, checked against a bit-counting parity model.
module tb_par_chk_rx;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          in_bit    [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] out_data  [2];
    logic          out_perr  [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [7:0]    err_cnt   [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_cnt  [2];
    logic [DW:0] exp_q [$];

    par_chk_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst),
        .in_bit(in_bit[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_perr(out_perr[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .err_cnt(err_cnt[0])
    );

    par_chk_rx #(.DATA_W(DW), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst),
        .in_bit(in_bit[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_perr(out_perr[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .err_cnt(err_cnt[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model: parity judged from the total number of ones in the frame
    function automatic logic model_perr(input logic [DW-1:0] d, input logic p, input int idx);
        int ones;
        ones = $countones(d) + int'(p);
        return (idx == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic logic [7:0] model_err(input int n);
`ifdef PAR_CHK_ERRCNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return (n >= 0) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic tick(input int idx);
        @(posedge clk);
        #1;
        in_bit[idx] = 1'($urandom_range(0, 1));
    endtask

    // drivers
    task automatic send_bit(input int idx, input logic b);
        int w;
        w = 0;
        while (in_ready[idx] !== 1'b1 && w < 40) begin
            tick(idx);
            w++;
        end
        if (w == 40) check("in_ready_timeout", 32'(in_ready[idx]), 32'd1);
        in_valid[idx] = 1'b1;
        in_bit[idx]   = b;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        in_bit[idx]   = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bits(input int idx, input logic [DW-1:0] d, input int nbits, input int maxgap);
        for (int i = 0; i < nbits; i++) begin
            repeat ($urandom_range(0, maxgap)) tick(idx);
            send_bit(idx, d[i]);
        end
    endtask

    task automatic send_frame(input int idx, input logic [DW-1:0] d, input logic p, input int maxgap);
        logic pe;
        send_bits(idx, d, DW, maxgap);
        repeat ($urandom_range(0, maxgap)) tick(idx);
        pe = model_perr(d, p, idx);
        if (pe) bad_cnt[idx]++;
        exp_q.push_back({pe, d});
        send_bit(idx, p);
    endtask

    // scoreboard side: entered #1 after the parity-bit edge
    task automatic collect(input int idx, input int hold, input string tag);
        logic [DW:0] e;
        e = exp_q.pop_front();
        if (hold > 0) out_ready[idx] = 1'b0;
        check({tag, "_valid"}, 32'(out_valid[idx]), 32'd1);
        check({tag, "_data"}, 32'(out_data[idx]), 32'(e[DW-1:0]));
        check({tag, "_perr"}, 32'(out_perr[idx]), 32'(e[DW]));
        check({tag, "_inrdy_lo"}, 32'(in_ready[idx]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick(idx);
            check({tag, "_hold_valid"}, 32'(out_valid[idx]), 32'd1);
            check({tag, "_hold_data"}, 32'(out_data[idx]), 32'(e[DW-1:0]));
            check({tag, "_hold_inrdy"}, 32'(in_ready[idx]), 32'd0);
        end
        out_ready[idx] = 1'b1;
        tick(idx);
        check({tag, "_valid_drop"}, 32'(out_valid[idx]), 32'd0);
        check({tag, "_inrdy_back"}, 32'(in_ready[idx]), 32'd1);
        check({tag, "_data_kept"}, 32'(out_data[idx]), 32'(e[DW-1:0]));
        check({tag, "_errcnt"}, 32'(err_cnt[idx]), 32'(model_err(bad_cnt[idx])));
    endtask

    initial begin
        int t0;
        int t1;
        logic [DW-1:0] d;
        logic p;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_bit[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b1; bad_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", 32'(out_valid[i]), 32'd0);
            check("rst_data", 32'(out_data[i]), 32'd0);
            check("rst_perr", 32'(out_perr[i]), 32'd0);
            check("rst_inrdy", 32'(in_ready[i]), 32'd1);
            check("rst_errcnt", 32'(err_cnt[i]), 32'd0);
        end

        // good and bad parity on 0xA5
        send_frame(0, 8'hA5, 1'b0, 0);
        collect(0, 0, "a5_good");
        send_frame(0, 8'hA5, 1'b1, 0);
        collect(0, 0, "a5_bad");

        // consumer stalls for 5 cycles; in_bit activity must be ignored meanwhile
        send_frame(0, 8'h5A, 1'b0, 0);
        in_valid[0] = 1'b1;
        collect(0, 5, "stall");
        in_valid[0] = 1'b0;
        send_frame(0, 8'hC3, 1'b0, 0);
        collect(0, 0, "after_stall");

        // idle gaps inside a frame
        send_frame(0, 8'h3C, 1'b0, 3);
        collect(0, 0, "gaps");

        // back-to-back frames at full rate
        send_frame(0, 8'h11, 1'b0, 0);
        collect(0, 0, "tput0");
        t0 = cyc;
        send_frame(0, 8'hEE, 1'b1, 0);
        t1 = cyc;
        collect(0, 0, "tput1");
        check("tput_period", 32'(t1 - t0 + 1), 32'(DW + 2));

        // randomized frames, gaps and consumer stalls
        for (int k = 0; k < 30; k++) begin
            d = DW'($urandom);
            p = 1'($urandom_range(0, 1));
            send_frame(0, d, p, 3);
            collect(0, $urandom_range(0, 3), "rand");
        end

        // reset mid-frame discards it
        send_bits(0, 8'hFF, 4, 1);
        rst = 1'b1;
        tick(0);
        rst = 1'b0;
        bad_cnt[0] = 0;
        bad_cnt[1] = 0;
        check("abort_valid", 32'(out_valid[0]), 32'd0);
        check("abort_inrdy", 32'(in_ready[0]), 32'd1);
        check("abort_errcnt", 32'(err_cnt[0]), 32'd0);
        send_frame(0, 8'h81, 1'b0, 0);
        collect(0, 0, "post_abort");
        repeat (12) begin
            tick(0);
            check("post_abort_no_extra", 32'(out_valid[0]), 32'd0);
        end

        // odd parity instance, then error-counter saturation
        send_frame(1, 8'h00, 1'b1, 0);
        collect(1, 0, "odd_good");
        for (int k = 0; k < 300; k++) begin
            d = DW'($urandom);
            p = ^d;
            send_frame(1, d, p, 0);
            collect(1, 0, "odd_bad");
        end
        check("errcnt_sat", 32'(err_cnt[1]), 32'(model_err(300)));
        send_frame(1, 8'h01, 1'b0, 0);
        collect(1, 0, "odd_good_after_sat");
        check("errcnt_even_dut", 32'(err_cnt[0]), 32'(model_err(bad_cnt[0])));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
